// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues one SRAM-like bus transaction per load/store,
// stalls the pipeline until it completes, and drains transactions orphaned by a flush.
module mem_dbus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ls_ena,
  input  logic [3:0]  mem_ls_sel,
  input  logic [31:0] mem_ls_addr,
  input  logic [31:0] mem_rt_data,
  input  logic        mem_has_exception,
  input  logic        exception_flush,
  input  logic        stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_load_data,
  output logic        mem_stall_req
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] load_q, load_d;
  logic        start, is_store, req, stall_req;
  logic [1:0]  size;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext, wdata;

  assign start    = mem_ls_ena & ~mem_has_exception & ~exception_flush;
  assign is_store = mem_ls_sel[3];
  // Reserved size encoding falls back to a full word.
  assign size     = (mem_ls_sel[1:0] == 2'b11) ? 2'b10 : mem_ls_sel[1:0];
  assign rd_byte  = data_rdata[{mem_ls_addr[1:0], 3'b000} +: 8];
  assign rd_half  = data_rdata[{mem_ls_addr[1], 4'b0000} +: 16];

  always_comb begin
    wdata  = mem_rt_data;
    rd_ext = data_rdata;
    case (size)
      2'b00: begin
        wdata  = {4{mem_rt_data[7:0]}};
        rd_ext = {{24{~mem_ls_sel[2] & rd_byte[7]}}, rd_byte};
      end
      2'b01: begin
        wdata  = {2{mem_rt_data[15:0]}};
        rd_ext = {{16{~mem_ls_sel[2] & rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    req       = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        req       = start;
        stall_req = start;
        if (start) state_d = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        req       = 1'b1;
        stall_req = 1'b1;
        if (data_addr_ok)         state_d = exception_flush ? S_DRAIN : S_WAIT;
        else if (exception_flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (data_data_ok) begin
          state_d = exception_flush ? S_IDLE : S_DONE;
          if (!exception_flush && !is_store) load_d = rd_ext;
        end else if (exception_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!stall || exception_flush) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Hold a following memory instruction until the stale response is gone.
        stall_req = mem_ls_ena & ~mem_has_exception;
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      load_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  assign data_req      = req;
  assign data_wr       = req & is_store;
  assign data_size     = req ? size : 2'b00;
  assign data_addr     = req ? mem_ls_addr : 32'h0;
  assign data_wdata    = req ? wdata : 32'h0;
  assign mem_load_data = load_q;
  assign mem_stall_req = stall_req;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed plus randomized bench for mem_dbus_ctrl against a transaction-level model.
module tb_mem_dbus_ctrl;

  logic        clk, rst;
  logic        mem_ls_ena, mem_has_exception, exception_flush, stall;
  logic [3:0]  mem_ls_sel;
  logic [31:0] mem_ls_addr, mem_rt_data;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, mem_load_data;
  logic        mem_stall_req;

  int n_chk = 0, n_fail = 0;

  mem_dbus_ctrl dut (
    .clk(clk), .rst(rst), .mem_ls_ena(mem_ls_ena), .mem_ls_sel(mem_ls_sel),
    .mem_ls_addr(mem_ls_addr), .mem_rt_data(mem_rt_data),
    .mem_has_exception(mem_has_exception), .exception_flush(exception_flush),
    .stall(stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_load_data(mem_load_data), .mem_stall_req(mem_stall_req)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Model: request pending, accepted-and-outstanding, outstanding-but-stale, result held.
  logic        m_pend = 0, m_busy = 0, m_stale = 0, m_done = 0, adv = 1;
  logic [31:0] m_load = 0;

  function automatic logic m_start();
    return mem_ls_ena && !mem_has_exception && !exception_flush;
  endfunction
  function automatic logic m_idle();
    return !m_pend && !m_busy && !m_done;
  endfunction
  function automatic logic m_req();
    return m_pend || (m_idle() && m_start());
  endfunction
  function automatic logic m_stall();
    return m_pend || (m_busy && !m_stale) || (m_idle() && m_start())
        || (m_busy && m_stale && mem_ls_ena && !mem_has_exception);
  endfunction

  function automatic logic [31:0] m_ext(input logic [3:0] sel, input logic [31:0] a,
                                        input logic [31:0] rd);
    logic [31:0] v;
    if (sel[1:0] == 2'd0) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!sel[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sel[1:0] == 2'd1) begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (!sel[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] sel, input logic [31:0] rt);
    logic [31:0] b, h;
    b = {24'h0, rt[7:0]};
    h = {16'h0, rt[15:0]};
    if (sel[1:0] == 2'd0) return b * 32'h0101_0101;
    if (sel[1:0] == 2'd1) return h * 32'h0001_0001;
    return rt;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_pend = 0; m_busy = 0; m_stale = 0; m_done = 0; m_load = 0; adv = 1;
    end else begin
      adv = (!m_stall() && !stall) || exception_flush;
      if (m_done) begin
        if (!stall || exception_flush) m_done = 0;
      end else if (m_busy) begin
        if (data_data_ok) begin
          if (!m_stale && !exception_flush) begin
            m_done = 1;
            if (!mem_ls_sel[3]) m_load = m_ext(mem_ls_sel, mem_ls_addr, data_rdata);
          end
          m_busy = 0; m_stale = 0;
        end else if (exception_flush) m_stale = 1;
      end else if (m_pend || m_start()) begin
        if (data_addr_ok) begin
          m_busy = 1; m_stale = exception_flush; m_pend = 0;
        end else m_pend = !exception_flush;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic er;
    er = m_req();
    chk("req", data_req, er);
    chk("stall_req", mem_stall_req, m_stall());
    chk("load_data", mem_load_data, m_load);
    if (er) begin
      chk("wr", data_wr, mem_ls_sel[3]);
      chk("size", data_size, (mem_ls_sel[1:0] == 2'd3) ? 32'd2 : mem_ls_sel[1:0]);
      chk("addr", data_addr, mem_ls_addr);
      chk("wdata", data_wdata, m_wdata(mem_ls_sel, mem_rt_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic e, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] rt, input logic x);
    mem_ls_ena = e; mem_ls_sel = s; mem_ls_addr = a; mem_rt_data = rt; mem_has_exception = x;
  endtask
  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
  endtask

  initial begin
    rst = 0; exception_flush = 0; stall = 0;
    ins(0, 4'h0, 32'h0, 32'h0, 0); bus(0, 0, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("rst_req", data_req, 0); chk("rst_stall", mem_stall_req, 0);
    chk("rst_wr", data_wr, 0); chk("rst_size", data_size, 0);
    chk("rst_load", mem_load_data, 0);

    // Zero-wait LB
    tick(); rst = 1; ins(1, 4'b0000, 32'h1003, 0, 0); bus(1, 0, 0);
    @(negedge clk); chk("lb_c0_req", data_req, 1); chk("lb_c0_stall", mem_stall_req, 1);
    tick(); bus(0, 1, 32'h80AB_CDEF);
    @(negedge clk); chk("lb_c1_req", data_req, 0); chk("lb_c1_stall", mem_stall_req, 1);
    tick(); bus(0, 0, 0);
    @(negedge clk); chk("lb_c2_load", mem_load_data, 32'hFFFF_FF80);
    chk("lb_c2_stall", mem_stall_req, 0); chk("lb_c2_req", data_req, 0);

    // Delayed SH
    tick(); ins(1, 4'b1001, 32'h2002, 32'h0000_1234, 0);
    for (int i = 0; i < 4; i++) begin
      bus(i == 3, 0, 0);
      @(negedge clk);
      chk("sh_req", data_req, 1); chk("sh_wdata", data_wdata, 32'h1234_1234);
      chk("sh_size", data_size, 1); chk("sh_wr", data_wr, 1);
      tick();
    end
    bus(0, 1, 0);
    @(negedge clk); chk("sh_wait_req", data_req, 0); chk("sh_wait_stall", mem_stall_req, 1);
    tick(); bus(0, 0, 0);
    @(negedge clk); chk("sh_done_stall", mem_stall_req, 0);
    tick(); ins(0, 0, 0, 0, 0);
    @(negedge clk); chk("sh_idle_req", data_req, 0);

    // LHU with external stall in DONE
    tick(); ins(1, 4'b0101, 32'h0002, 0, 0); bus(1, 0, 0);
    tick(); bus(0, 1, 32'h8001_0000);
    tick(); bus(0, 0, 0); stall = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lhu_load", mem_load_data, 32'h0000_8001); chk("lhu_noreq", data_req, 0);
      tick();
    end
    stall = 0;
    @(negedge clk); chk("lhu_rel_req", data_req, 0); chk("lhu_rel_stall", mem_stall_req, 0);
    tick(); ins(0, 0, 0, 0, 0);

    // Flush while in REQ
    tick(); ins(1, 4'b0010, 32'h10, 0, 0);
    @(negedge clk); chk("fl_c0_req", data_req, 1);
    tick(); exception_flush = 1;
    @(negedge clk); chk("fl_c1_req", data_req, 1);
    tick(); exception_flush = 0; ins(0, 0, 0, 0, 0);
    @(negedge clk); chk("fl_c2_req", data_req, 0); chk("fl_c2_stall", mem_stall_req, 0);
    chk("fl_c2_load", mem_load_data, 32'h0000_8001);

    // Flush in WAIT, new LW during DRAIN
    tick(); ins(1, 4'b0010, 32'h20, 0, 0); bus(1, 0, 0);
    tick(); bus(0, 0, 0); exception_flush = 1;
    @(negedge clk); chk("dr_c1_stall", mem_stall_req, 1);
    tick(); exception_flush = 0; ins(1, 4'b0010, 32'h30, 0, 0);
    @(negedge clk); chk("dr_c2_req", data_req, 0); chk("dr_c2_stall", mem_stall_req, 1);
    tick(); bus(0, 1, 32'hDEAD_BEEF);
    @(negedge clk); chk("dr_c3_req", data_req, 0); chk("dr_c3_stall", mem_stall_req, 1);
    tick(); bus(1, 0, 0);
    @(negedge clk); chk("dr_c4_req", data_req, 1); chk("dr_c4_load", mem_load_data, 32'h0000_8001);
    tick(); bus(0, 1, 32'h1122_3344);
    tick(); bus(0, 0, 0);
    @(negedge clk); chk("dr_c6_load", mem_load_data, 32'h1122_3344);
    tick(); ins(0, 0, 0, 0, 0);

    // Suppressed access, then reset while in WAIT
    tick(); ins(1, 4'b0010, 32'h40, 0, 1);
    @(negedge clk); chk("sup_req", data_req, 0); chk("sup_stall", mem_stall_req, 0);
    tick(); ins(1, 4'b0010, 32'h44, 0, 0); bus(1, 0, 0);
    tick(); bus(0, 0, 0); rst = 0;
    @(negedge clk); chk("rw_stall", mem_stall_req, 1);
    tick(); rst = 1; ins(0, 0, 0, 0, 0);
    @(negedge clk); chk("rw_req", data_req, 0); chk("rw_stall0", mem_stall_req, 0);
    chk("rw_load", mem_load_data, 0); chk("rw_wr", data_wr, 0); chk("rw_size", data_size, 0);

    // Randomized traffic
    repeat (4000) begin
      tick();
      if (adv) ins($urandom % 4 != 0, 4'($urandom), $urandom, $urandom, $urandom % 8 == 0);
      stall = ($urandom % 4) == 0;
      exception_flush = ($urandom % 16) == 0;
      data_rdata = $urandom;
      data_addr_ok = m_req() && ($urandom % 3 == 0);
      data_data_ok = m_busy && ($urandom % 3 == 0);
    end
    tick();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
